alarm_trigger: RTL and testbench

Alarm-time store and trigger generator: holds two user-settable BCD alarm times, lets the user edit and enable them from the debounced key bus, and compares them against the running clock. On a match it emits a one-cycle pulse on `alarm_up_clk[n]`, the trigger input consumed by the alarm/buzzer player. It sits between the time-keeping counter (source of `clock_data`) and the alarm player, and also drives the display mux with the selected alarm time.

---
 rtl/alarm_trigger.sv | 126 ++++++++++++
 tb/tb_alarm_trigger.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// Alarm-time store and trigger generator: two editable BCD alarms compared against clock_data.
// Optional ALARM_ONESHOT_EN: an alarm's enable clears on the cycle it fires.
module alarm_trigger #(
  parameter logic [23:0] ALARM1_INIT = 24'h070000,
  parameter logic [23:0] ALARM2_INIT = 24'h120000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  key,
  input  logic [23:0] clock_data,
  output logic [1:0]  alarm_up_clk,
  output logic [23:0] alarm_data,
  output logic [1:0]  alarm_en,
  output logic [1:0]  set_state,
  output logic        alarm_sel
);

  localparam int unsigned HM_W = 16;
  localparam int unsigned TIME_W = 24;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOUR = 2'd1;
  localparam logic [1:0] S_MIN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              alarm_sel_q, alarm_sel_d;
  logic [1:0]        alarm_en_q, alarm_en_d;
  logic [HM_W-1:0]   alarm1_q, alarm1_d;
  logic [HM_W-1:0]   alarm2_q, alarm2_d;
  logic [1:0]        match_q, match_d;
  logic [1:0]        alarm_up_clk_q, alarm_up_clk_d;
  logic [TIME_W-1:0] alarm_data_q, alarm_data_d;
  logic [HM_W-1:0]   sel_hm, edit_hm;
  logic              time_zero_sec;
  logic              unused_player_keys;

  assign unused_player_keys = ^key[3:2];

  // BCD hour increment, 23 wraps to 00
  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if (h == 8'h23)         inc_hour = 8'h00;
    else if (h[3:0] == 4'd9) inc_hour = {h[7:4] + 4'd1, 4'd0};
    else                     inc_hour = {h[7:4], h[3:0] + 4'd1};
  endfunction

  // BCD minute increment, 59 wraps to 00 without touching the hour
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == 8'h59)         inc_min = 8'h00;
    else if (m[3:0] == 4'd9) inc_min = {m[7:4] + 4'd1, 4'd0};
    else                     inc_min = {m[7:4], m[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_d        = state_q;
    alarm_sel_d    = alarm_sel_q;
    alarm_en_d     = alarm_en_q;
    alarm1_d       = alarm1_q;
    alarm2_d       = alarm2_q;
    sel_hm         = alarm_sel_q ? alarm2_q : alarm1_q;
    edit_hm        = sel_hm;
    time_zero_sec  = (clock_data[7:0] == 8'h00);

    // The alarm being edited is masked so a half-edited value cannot fire
    match_d[0] = alarm_en_q[0] && (clock_data[23:8] == alarm1_q) && time_zero_sec
                 && !((state_q != S_IDLE) && !alarm_sel_q);
    match_d[1] = alarm_en_q[1] && (clock_data[23:8] == alarm2_q) && time_zero_sec
                 && !((state_q != S_IDLE) && alarm_sel_q);
    alarm_up_clk_d = match_d & ~match_q;

    // One key per cycle: MODE > UP > SEL; unlisted keys are dropped
    case (state_q)
      S_IDLE: begin
        if (key[0])      state_d = S_HOUR;
        else if (key[1]) alarm_en_d[alarm_sel_q] = ~alarm_en_q[alarm_sel_q];
        else if (key[4]) alarm_sel_d = ~alarm_sel_q;
      end
      S_HOUR: begin
        if (key[0])      state_d = S_MIN;
        else if (key[1]) edit_hm = {inc_hour(sel_hm[15:8]), sel_hm[7:0]};
      end
      S_MIN: begin
        if (key[0])      state_d = S_IDLE;
        else if (key[1]) edit_hm = {sel_hm[15:8], inc_min(sel_hm[7:0])};
      end
      default: state_d = S_IDLE;
    endcase

    if (alarm_sel_q) alarm2_d = edit_hm;
    else             alarm1_d = edit_hm;

`ifdef ALARM_ONESHOT_EN
    alarm_en_d = alarm_en_d & ~alarm_up_clk_d;
`endif

    alarm_data_d = {(alarm_sel_d ? alarm2_d : alarm1_d), 8'h00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      alarm_sel_q    <= 1'b0;
      alarm_en_q     <= 2'b00;
      alarm1_q       <= ALARM1_INIT[23:8];
      alarm2_q       <= ALARM2_INIT[23:8];
      match_q        <= 2'b00;
      alarm_up_clk_q <= 2'b00;
      alarm_data_q   <= {ALARM1_INIT[23:8], 8'h00};
    end else begin
      state_q        <= state_d;
      alarm_sel_q    <= alarm_sel_d;
      alarm_en_q     <= alarm_en_d;
      alarm1_q       <= alarm1_d;
      alarm2_q       <= alarm2_d;
      match_q        <= match_d;
      alarm_up_clk_q <= alarm_up_clk_d;
      alarm_data_q   <= alarm_data_d;
    end
  end

  assign alarm_up_clk = alarm_up_clk_q;
  assign alarm_data   = alarm_data_q;
  assign alarm_en     = alarm_en_q;
  assign set_state    = state_q;
  assign alarm_sel    = alarm_sel_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: integer-time reference model feeds a scoreboard queue checked by a monitor.
module tb_alarm_trigger;

  typedef struct {
    logic [1:0]  up;
    logic [23:0] data;
    logic [1:0]  en;
    logic [1:0]  st;
    logic        sel;
  } exp_t;

  localparam logic [4:0] K_MODE = 5'b00001;
  localparam logic [4:0] K_UP   = 5'b00010;
  localparam logic [4:0] K_SEL  = 5'b10000;
  localparam logic [4:0] K_NONE = 5'b00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  key;
  logic [23:0] clock_data;
  logic [1:0]  alarm_up_clk;
  logic [23:0] alarm_data;
  logic [1:0]  alarm_en;
  logic [1:0]  set_state;
  logic        alarm_sel;

  always #5 clk = ~clk;

  alarm_trigger dut (
    .clk(clk), .rst_n(rst_n), .key(key), .clock_data(clock_data),
    .alarm_up_clk(alarm_up_clk), .alarm_data(alarm_data), .alarm_en(alarm_en),
    .set_state(set_state), .alarm_sel(alarm_sel)
  );

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pulse0_cnt = 0;

  // Reference model: alarm times kept as plain hour/minute integers
  int       m_st;
  bit       m_sel;
  bit [1:0] m_en;
  bit [1:0] m_hist;
  int       m_hr[2];
  int       m_mn[2];

  function automatic logic [7:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] k, input int h, input int m, input int s);
    exp_t e;
    bit [1:0] match;
    bit [1:0] pulse;
    @(negedge clk);
    rst_n = r;
    key = k;
    clock_data = {bcd(h), bcd(m), bcd(s)};
    if (!r) begin
      m_st = 0; m_sel = 1'b0; m_en = 2'b00; m_hist = 2'b00;
      m_hr[0] = 7; m_mn[0] = 0; m_hr[1] = 12; m_mn[1] = 0;
      pulse = 2'b00;
    end else begin
      for (int n = 0; n < 2; n++)
        match[n] = m_en[n] && (h == m_hr[n]) && (m == m_mn[n]) && (s == 0)
                   && !((m_st != 0) && (int'(m_sel) == n));
      pulse = match & ~m_hist;
      m_hist = match;
      if (k[0]) m_st = (m_st + 1) % 3;
      else if (k[1]) begin
        if (m_st == 0)      m_en[m_sel] = ~m_en[m_sel];
        else if (m_st == 1) m_hr[m_sel] = (m_hr[m_sel] + 1) % 24;
        else                m_mn[m_sel] = (m_mn[m_sel] + 1) % 60;
      end else if (k[4] && m_st == 0) m_sel = ~m_sel;
`ifdef ALARM_ONESHOT_EN
      m_en = m_en & ~pulse;
`endif
    end
    e.up   = pulse;
    e.data = {bcd(m_hr[m_sel]), bcd(m_mn[m_sel]), 8'h00};
    e.en   = m_en;
    e.st   = 2'(m_st);
    e.sel  = m_sel;
    q.push_back(e);
  endtask

  task automatic keys(input logic [4:0] k, input int count, input int h, input int m, input int s);
    for (int i = 0; i < count; i++) step(1'b1, k, h, m, s);
  endtask

  // Monitor: every cycle with a pending expectation is compared field by field
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("alarm_up_clk", 24'(alarm_up_clk), 24'(e.up));
        cmp("alarm_data",   alarm_data,        e.data);
        cmp("alarm_en",     24'(alarm_en),     24'(e.en));
        cmp("set_state",    24'(set_state),    24'(e.st));
        cmp("alarm_sel",    24'(alarm_sel),    24'(e.sel));
        if (alarm_up_clk[0]) pulse0_cnt++;
      end
    end
  end

  initial begin
    int rh, rm, rs, c, r;
    logic [4:0] k;
    rst_n = 1'b0; key = K_NONE; clock_data = 24'h0;
    step(1'b0, K_NONE, 5, 30, 0);
    step(1'b0, K_NONE, 5, 30, 0);
    keys(K_NONE, 2, 5, 30, 0);

    // Alarm 1 -> 10:12, enable, then hold the matching time
    keys(K_MODE, 1, 5, 30, 0);
    keys(K_UP,   3, 5, 30, 0);
    keys(K_MODE, 1, 5, 30, 0);
    keys(K_UP,  12, 5, 30, 0);
    keys(K_MODE, 1, 5, 30, 0);
    keys(K_UP,   1, 5, 30, 0);
    pulse0_cnt = 0;
    keys(K_NONE, 5, 10, 12, 0);
    keys(K_NONE, 3, 10, 12, 1);
    @(posedge clk);
    #2;
    cmp("alarm1_single_pulse", 24'(pulse0_cnt), 24'd1);
    keys(K_NONE, 2, 5, 30, 0);
    keys(K_NONE, 3, 10, 12, 0);

    // Hour wraps 23 -> 00, minute wraps 59 -> 00 without touching the hour
    keys(K_MODE, 1, 5, 30, 0);
    keys(K_UP,  14, 5, 30, 0);
    keys(K_MODE, 1, 5, 30, 0);
    keys(K_UP,  48, 5, 30, 0);
    keys(K_MODE, 1, 5, 30, 0);

    // Both alarms at 12:00, then mask alarm 2 while editing it
    step(1'b0, K_NONE, 11, 59, 59);
    keys(K_MODE, 1, 11, 59, 59);
    keys(K_UP,   5, 11, 59, 59);
    keys(K_MODE, 2, 11, 59, 59);
    keys(K_UP,   1, 11, 59, 59);
    keys(K_SEL,  1, 11, 59, 59);
    keys(K_UP,   1, 11, 59, 59);
    keys(K_NONE, 3, 12, 0, 0);
    keys(K_NONE, 1, 11, 0, 0);
    keys(K_MODE, 2, 11, 0, 0);
    keys(K_NONE, 3, 12, 0, 0);
    keys(K_MODE, 1, 12, 0, 0);
    keys(K_NONE, 3, 12, 0, 0);

    // Randomized traffic with times steered onto the alarm settings
    rh = 12; rm = 0; rs = 0;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       k = K_MODE;
      else if (r < 22) k = K_UP;
      else if (r < 30) k = K_SEL;
      else if (r < 34) k = 5'($urandom);
      else             k = K_NONE;
      if ($urandom_range(0, 3) == 0) begin
        c = $urandom_range(0, 5);
        if (c < 2 && m_hr[c] >= 0) begin
          rh = m_hr[c]; rm = m_mn[c];
          rs = ($urandom_range(0, 2) != 0) ? 0 : $urandom_range(1, 59);
        end else begin
          rh = $urandom_range(0, 23); rm = $urandom_range(0, 59); rs = $urandom_range(0, 59);
        end
      end
      step(($urandom_range(0, 199) != 0), k, rh, rm, rs);
    end
    keys(K_NONE, 2, 0, 0, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
